// File: rtl/div_pkg.sv
// Shared parameters and types for the serial-divider quotient emitter.
// Holds the frame/digit sizing, the emitter state encoding and the double-dabble nibble fix-up.
package div_pkg;

  localparam int QW = 10;
  localparam int ND = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CONV,
    OUT
  } emit_state_e;

  typedef logic [3:0] bcd_t;

  // Double-dabble correction applied to each nibble before every shift.
  function automatic bcd_t dabbleAdj(input bcd_t n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-and-adjust iteration per cycle.
// Needs QW cycles after start_i; done_o marks the cycle whose edge commits the final iteration.
module bin2bcd_seq
  import div_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [QW-1:0]     bin_i,
  output logic              done_o,
  output bcd_t [ND-1:0]     bcd_o
);

  localparam int WW = ND * 4 + QW;
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  logic [WW-1:0] work_q, work_d;
  logic [WW-1:0] workAdj;
  logic [IW-1:0] iter_q, iter_d;
  logic          busy_q, busy_d;
  logic          lastIter;

  assign lastIter = busy_q && (iter_q == IW'(QW - 1));
  assign done_o   = lastIter;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      work_q <= work_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  // The binary operand sits in the low QW bits; the BCD field grows above it.
  always_comb begin
    workAdj = work_q;
    for (int i = 0; i < ND; i++) begin
      workAdj[QW + 4 * i +: 4] = dabbleAdj(work_q[QW + 4 * i +: 4]);
    end
  end

  always_comb begin
    work_d = work_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (start_i) begin
      work_d = WW'(bin_i);
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      work_d = {workAdj[WW-2:0], 1'b0};
      iter_d = iter_q + IW'(1);
      if (lastIter) begin
        busy_d = 1'b0;
        iter_d = '0;
      end
    end
  end

  always_comb begin
    bcd_o = '0;
    for (int i = 0; i < ND; i++) begin
      bcd_o[i] = work_q[QW + 4 * i +: 4];
    end
  end

endmodule

// File: rtl/quotient_bcd_emitter.sv
// Captures the divider's MSB-first serial quotient, converts it to BCD and
// streams the digits most significant first, one per cycle, with registered outputs.
module quotient_bcd_emitter
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_err
);

  localparam int CW = $clog2(QW + 1);
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;

  emit_state_e   state_q, state_d;
  logic [QW-2:0] shift_q, shift_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic [DW-1:0] digit_q, digit_d;
  logic          armed_q, armed_d;
  logic          err_q, err_d;
  logic          outValid_d, outErr_d;
  logic [3:0]    outData_d;

  logic [QW-1:0] frameWord;
  logic          convStart;
  logic          convDone;
  bcd_t [ND-1:0] bcdDigits;

  assign frameWord = {shift_q, in_data};

  bin2bcd_seq u_conv (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (convStart),
    .bin_i   (frameWord),
    .done_o  (convDone),
    .bcd_o   (bcdDigits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      digit_q  <= '0;
      armed_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      digit_q  <= digit_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
    end
  end

  // Any in_valid seen while busy disarms until the line drops, so a frame
  // overlapping CONV/OUT is never picked up halfway through.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    digit_d   = digit_q;
    err_d     = err_q;
    convStart = 1'b0;
    armed_d   = armed_q;
    if (!in_valid) begin
      armed_d = 1'b1;
    end else if (state_q == CONV || state_q == OUT) begin
      armed_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && armed_q) begin
          shift_d  = (QW-1)'(in_data);
          bitCnt_d = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          shift_d  = frameWord[QW-2:0];
          bitCnt_d = bitCnt_q + CW'(1);
          if (bitCnt_q == CW'(QW - 1)) begin
            convStart = 1'b1;
            err_d     = &frameWord;
            bitCnt_d  = '0;
            state_d   = CONV;
          end
        end else begin
          shift_d  = '0;
          bitCnt_d = '0;
          state_d  = IDLE;
        end
      end
      CONV: begin
        if (convDone) begin
          digit_d = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        digit_d = digit_q + DW'(1);
        if (digit_q == DW'(ND - 1)) begin
          digit_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outValid_d = 1'b0;
    outData_d  = 4'd0;
    outErr_d   = 1'b0;
    if (state_q == OUT) begin
      outValid_d = 1'b1;
      outData_d  = bcdDigits[DW'(ND - 1) - digit_q];
      outErr_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= outValid_d;
      out_data  <= outData_d;
      out_err   <= outErr_d;
    end
  end

endmodule

// File: tb/tb_quotient_bcd_emitter.sv
// Self-checking bench for quotient_bcd_emitter: a frame-level reference model
// predicts every output cycle, and directed tests pin digits and latency literally.
module tb_quotient_bcd_emitter;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_err;

  int vectors = 0;
  int miscompares = 0;

  quotient_bcd_emitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Reference model: counts edges, assembles accepted frames and schedules
  // {err, digit} for each output cycle at last-bit edge + QW + 1 onwards.
  int         cyc = 0;
  int         idleFrom = 0;
  bit         collecting = 1'b0;
  bit         modelArmed = 1'b1;
  int         acc = 0;
  int         nBits = 0;
  logic [4:0] expMap [int];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expMap.delete();
      collecting = 1'b0;
      modelArmed = 1'b1;
      idleFrom   = 0;
    end else begin
      cyc++;
      if (collecting) begin
        if (in_valid) begin
          acc = acc * 2 + int'(in_data);
          nBits++;
          if (nBits == QW) begin
            collecting = 1'b0;
            for (int d = 0; d < ND; d++) begin
              int div;
              div = 1;
              for (int k = 0; k < ND - 1 - d; k++) div = div * 10;
              expMap[cyc + QW + 1 + d] = {acc == (1 << QW) - 1, 4'((acc / div) % 10)};
            end
            idleFrom = cyc + QW + ND + 1;
          end
        end else begin
          collecting = 1'b0;
        end
      end else if (in_valid && modelArmed && cyc >= idleFrom) begin
        collecting = 1'b1;
        acc   = int'(in_data);
        nBits = 1;
      end else if (in_valid) begin
        modelArmed = 1'b0;
      end
      if (!in_valid) modelArmed = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison plus a recorder of the emitted digit stream.
  int dq[$];
  int eq[$];
  int firstCyc = 0;
  int lastEdge = 0;

  always @(negedge clk) begin
    logic [5:0] expW;
    expW = expMap.exists(cyc) ? {1'b1, expMap[cyc]} : 6'd0;
    checkOutput("cycle_outputs", int'({out_valid, out_err, out_data}), int'(expW));
    if (out_valid) begin
      if (dq.size() == 0) firstCyc = cyc;
      dq.push_back(int'(out_data));
      eq.push_back(int'(out_err));
    end
  end

  task automatic applyStimulus(input int value, input int nValid);
    for (int i = 0; i < nValid; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i < QW) ? value[QW - 1 - i] : 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 1'b0;
    lastEdge = cyc - (nValid - QW);
  endtask

  task automatic checkDigits(input string name, input logic [15:0] expD, input int expErr);
    checkOutput({name, "_count"}, dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      checkOutput({name, "_digit"}, dq[i], int'(expD[15 - 4 * i -: 4]));
      checkOutput({name, "_err"}, eq[i], expErr);
    end
    dq.delete();
    eq.delete();
  endtask

  task automatic settle();
    repeat (QW + ND + 4) @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_data", int'(out_data), 0);
    checkOutput("reset_err", int'(out_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] test 1: frame 113");
    dq.delete(); eq.delete();
    applyStimulus(113, QW);
    settle();
    checkOutput("t1_latency", firstCyc - lastEdge, QW + 1);
    checkDigits("t1", 16'h0113, 0);

    $display("[TB] test 2: all ones");
    applyStimulus(1023, QW);
    settle();
    checkDigits("t2", 16'h1023, 1);

    $display("[TB] test 3: all zeros");
    applyStimulus(0, QW);
    settle();
    checkDigits("t3", 16'h0000, 0);

    $display("[TB] test 4: short frame then 999");
    applyStimulus(999, 5);
    applyStimulus(999, QW);
    settle();
    checkDigits("t4", 16'h0999, 0);

    $display("[TB] test 5: long frame 512 and a frame lost during CONV/OUT");
    applyStimulus(512, QW + 4);
    @(negedge clk);
    applyStimulus(777, QW);
    settle();
    checkDigits("t5", 16'h0512, 0);

    $display("[TB] test 6: reset during output");
    applyStimulus(999, QW);
    for (int k = 0; k < 40 && dq.size() < 2; k++) @(negedge clk);
    checkOutput("t6_reached_digit2", dq.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", int'(out_valid), 0);
    checkOutput("t6_rst_data", int'(out_data), 0);
    checkOutput("t6_rst_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dq.delete(); eq.delete();
    applyStimulus(7, QW);
    settle();
    checkOutput("t6_latency", firstCyc - lastEdge, QW + 1);
    checkDigits("t6", 16'h0007, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
